// File: rtl/aib_cfg_pkg.sv
// aib_cfg_pkg - shared types and constants for the AIB configuration loader.
//   aib_cfg_state_e : loader FSM states (SETTLE, LOAD, DONE, ERR).
//   AIB_CFG_DEFAULT : per-register reset image used when the shadow bank
//                     is built in (AIB_CFG_SHADOW_EN).
package aib_cfg_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOAD   = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } aib_cfg_state_e;

  // Default register image: fixed signature in the upper bits, register
  // number in the low byte, so an unconfigured bank is easy to recognise.
  function automatic logic [31:0] AIB_CFG_DEFAULT(input int unsigned k);
    logic [31:0] k_w;
    k_w = k;
    AIB_CFG_DEFAULT = 32'hA1B0_0000 | {24'h00_0000, k_w[7:0]};
  endfunction

endpackage

// File: rtl/aib_cfg_loader_settle_cnt.sv
// aib_cfg_settle_cnt - post-reset settle timer.
// Counts SETTLE_CYC clock edges after reset release and raises tick_o for
// exactly one cycle, aligned so that a consumer registering on tick_o
// changes state on edge number SETTLE_CYC. Re-arms only through reset.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   tick_o : one-cycle terminal pulse
module aib_cfg_settle_cnt #(
  parameter int unsigned SETTLE_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             armed_q;

  // Down-counter from SETTLE_CYC-1; disarms itself once the terminal count fires.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= CNT_W'(SETTLE_CYC - 1);
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (cnt_q == '0) begin
        armed_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end else begin
      cnt_q   <= cnt_q;
      armed_q <= 1'b0;
    end
  end

  assign tick_o = armed_q & (cnt_q == '0);

endmodule

// File: rtl/aib_cfg_loader.sv
// aib_cfg_loader - configuration loader for the AIB channel.
// Streams NUM_REGS configuration words plus one XOR checksum word over a
// valid/ready handshake into the channel register bank, verifies the
// checksum and flags done (used to release system/adapter resets) or error.
// Optional feature macro: AIB_CFG_SHADOW_EN - words land in a shadow bank
// and the visible bank is committed atomically on successful verification.
// Ports:
//   i_aux_clk     : clock
//   i_rst         : asynchronous active-high reset
//   i_cfg_valid   : word valid          o_cfg_ready : loader accepts a word
//   i_cfg_data    : config/checksum     i_cfg_last  : marks checksum word
//   i_cfg_restart : restart loading pulse
//   o_cfg_regs    : register bank, reg k at [k*DATA_W +: DATA_W]
//   o_config_done : loaded and verified o_cfg_err   : sticky load error
//   o_busy        : settling or loading
module aib_cfg_loader
  import aib_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SETTLE_CYC = 64
) (
  input  logic                         i_aux_clk,
  input  logic                         i_rst,
  input  logic                         i_cfg_valid,
  output logic                         o_cfg_ready,
  input  logic [DATA_W-1:0]            i_cfg_data,
  input  logic                         i_cfg_last,
  input  logic                         i_cfg_restart,
  output logic [NUM_REGS*DATA_W-1:0]   o_cfg_regs,
  output logic                         o_config_done,
  output logic                         o_cfg_err,
  output logic                         o_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS + 1);
  localparam int unsigned ADR_W = $clog2(NUM_REGS);

  aib_cfg_state_e    state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [DATA_W-1:0] xor_q;
  logic [DATA_W-1:0] xor_d;
  logic              ready_q;
  logic              done_q;
  logic              err_q;
  logic              busy_q;
  logic [DATA_W-1:0] bank_q [NUM_REGS];
`ifdef AIB_CFG_SHADOW_EN
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
`endif

  logic              settle_tick_s;
  logic              hs_s;
  logic              at_cks_s;
  logic              cks_ok_s;
  logic [ADR_W-1:0]  wr_adr_s;

  aib_cfg_settle_cnt #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .clk_i  (i_aux_clk),
    .rst_i  (i_rst),
    .tick_o (settle_tick_s)
  );

  // ready_q is only ever set in LOAD, so it doubles as the LOAD qualifier.
  assign hs_s     = i_cfg_valid & ready_q;
  assign at_cks_s = (idx_q == IDX_W'(NUM_REGS));
  assign cks_ok_s = i_cfg_last & (i_cfg_data == xor_q);
  assign wr_adr_s = idx_q[ADR_W-1:0];
  assign idx_d    = idx_q + IDX_W'(1);
  assign xor_d    = xor_q ^ i_cfg_data;

  // Loader FSM with its datapath and registered status outputs.
  always_ff @(posedge i_aux_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= SETTLE;
      idx_q   <= '0;
      xor_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
      for (int k = 0; k < NUM_REGS; k++) begin
`ifdef AIB_CFG_SHADOW_EN
        bank_q[k]   <= DATA_W'(AIB_CFG_DEFAULT(k));
        shadow_q[k] <= DATA_W'(AIB_CFG_DEFAULT(k));
`else
        bank_q[k]   <= '0;
`endif
      end
    end else begin
      case (state_q)
        SETTLE: begin
          // Restart is deliberately ignored until the settle time has elapsed.
          if (settle_tick_s) begin
            state_q <= LOAD;
            ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (i_cfg_restart) begin
            // Restart beats a coincident handshake; that word is dropped.
            idx_q <= '0;
            xor_q <= '0;
          end else if (hs_s) begin
            if (!at_cks_s) begin
              if (i_cfg_last) begin
                // Premature last: abort without writing the word.
                state_q <= ERR;
                ready_q <= 1'b0;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
`ifdef AIB_CFG_SHADOW_EN
                shadow_q[wr_adr_s] <= i_cfg_data;
`else
                bank_q[wr_adr_s]   <= i_cfg_data;
`endif
                idx_q <= idx_d;
                xor_q <= xor_d;
              end
            end else if (cks_ok_s) begin
              state_q <= DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
`ifdef AIB_CFG_SHADOW_EN
              bank_q  <= shadow_q;
`endif
            end else begin
              state_q <= ERR;
              ready_q <= 1'b0;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        DONE, ERR: begin
          if (i_cfg_restart) begin
            state_q <= LOAD;
            idx_q   <= '0;
            xor_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= SETTLE;
          ready_q <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign o_cfg_regs[g*DATA_W +: DATA_W] = bank_q[g];
  end

  assign o_cfg_ready   = ready_q;
  assign o_config_done = done_q;
  assign o_cfg_err     = err_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_aib_cfg_loader.sv
// tb_aib_cfg_loader - self-checking bench for aib_cfg_loader.
// Randomised configuration passes (good, bad checksum, missing last,
// premature last) plus directed settle, restart and mid-load reset cases,
// checked against a pass-level reference model of the visible register bank.
`timescale 1ns/1ps
module tb_aib_cfg_loader;

  localparam int NUM_REGS   = 16;
  localparam int DATA_W     = 32;
  localparam int SETTLE_CYC = 64;
  localparam int BW         = NUM_REGS * DATA_W;
`ifdef AIB_CFG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              restart;
  logic [BW-1:0]     regs;
  logic              done;
  logic              err;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] exp_regs [NUM_REGS];
  logic [DATA_W-1:0] words    [NUM_REGS];

  always #5 clk = ~clk;

  aib_cfg_loader #(
    .NUM_REGS   (NUM_REGS),
    .DATA_W     (DATA_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .i_aux_clk     (clk),
    .i_rst         (rst),
    .i_cfg_valid   (valid),
    .o_cfg_ready   (ready),
    .i_cfg_data    (data),
    .i_cfg_last    (last),
    .i_cfg_restart (restart),
    .o_cfg_regs    (regs),
    .o_config_done (done),
    .o_cfg_err     (err),
    .o_busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [DATA_W-1:0] reset_word(input int k);
`ifdef AIB_CFG_SHADOW_EN
    return aib_cfg_pkg::AIB_CFG_DEFAULT(k);
`else
    return '0;
`endif
  endfunction

  function automatic logic [BW-1:0] exp_image();
    logic [BW-1:0] img;
    for (int k = 0; k < NUM_REGS; k++) img[k*DATA_W +: DATA_W] = exp_regs[k];
    return img;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic r, input logic d, input logic e, input logic b);
    check_eq({tag, ".ready"}, BW'(ready), BW'(r));
    check_eq({tag, ".done"},  BW'(done),  BW'(d));
    check_eq({tag, ".err"},   BW'(err),   BW'(e));
    check_eq({tag, ".busy"},  BW'(busy),  BW'(b));
    check_eq({tag, ".regs"},  regs,       exp_image());
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic assert_reset(input string tag);
    rst = 1'b1; valid = 1'b0; last = 1'b0; restart = 1'b0;
    #1;
    for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = reset_word(k);
    check_status(tag, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Releases reset with valid held high and measures the settle time.
  task automatic release_and_settle(input string tag);
    int n;
    step();
    step();
    rst = 1'b0;
    valid = 1'b1; data = $urandom; last = 1'b0; restart = 1'b1;
    n = 0;
    for (int c = 1; c <= 4 * SETTLE_CYC; c++) begin
      step();
      restart = 1'b0;
      if (ready === 1'b1) begin
        n = c;
        break;
      end
    end
    valid = 1'b0;
    check_eq({tag, ".settle_cycles"}, BW'(n), BW'(SETTLE_CYC));
    check_status({tag, ".settled"}, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send(input logic [DATA_W-1:0] w, input logic lst, input string tag);
    int gaps;
    gaps = $urandom_range(0, 2);
    for (int g = 0; g < gaps; g++) step();
    check_eq({tag, ".rdy_before"}, BW'(ready), BW'(1'b1));
    valid = 1'b1; data = w; last = lst;
    step();
    valid = 1'b0; last = 1'b0;
  endtask

  // kind 0: good; 1: checksum ^ bad; 2: good checksum without last;
  // 3: last flagged on data word p.
  task automatic run_pass(input string tag, input int kind, input int p, input logic [DATA_W-1:0] bad);
    logic [DATA_W-1:0] cs;
    int np;
    cs = '0;
    for (int i = 0; i < NUM_REGS; i++) cs = cs ^ words[i];
    np = (kind == 3) ? p : NUM_REGS;
    for (int i = 0; i < np; i++) begin
      send(words[i], 1'b0, tag);
      if (!SHADOW) exp_regs[i] = words[i];
      check_eq($sformatf("%s.wr%0d", tag, i), regs, exp_image());
    end
    case (kind)
      0: send(cs, 1'b1, tag);
      1: send(cs ^ bad, 1'b1, tag);
      2: send(cs, 1'b0, tag);
      default: send(words[p], 1'b1, tag);
    endcase
    if (kind == 0) begin
      if (SHADOW) for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = words[i];
      check_status({tag, ".end"}, 1'b0, 1'b1, 1'b0, 1'b0);
    end else begin
      check_status({tag, ".end"}, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    // Status must hold without restart.
    step();
    check_status({tag, ".hold"}, 1'b0, kind == 0, kind != 0, 1'b0);
  endtask

  task automatic restart_pulse(input string tag);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check_status(tag, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rand_words();
    for (int i = 0; i < NUM_REGS; i++) words[i] = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; data = '0; last = 1'b0; restart = 1'b0;
    assert_reset("reset");
    release_and_settle("boot");

    // Pattern stream whose XOR is zero.
    for (int k = 0; k < NUM_REGS; k++) words[k] = DATA_W'(k) * 32'h1111_1111;
    run_pass("pat_good", 0, 0, '0);
    restart_pulse("pat_good.rs");
    run_pass("pat_badcs", 1, 0, 32'hDEAD_BEEF);
    restart_pulse("pat_badcs.rs");

    // Premature last on word 5, then recovery.
    rand_words();
    run_pass("early5", 3, 5, '0);
    restart_pulse("early5.rs");
    rand_words();
    run_pass("recover", 0, 0, '0);
    restart_pulse("recover.rs");

    // Restart coinciding with the handshake of word 3.
    rand_words();
    for (int i = 0; i < 3; i++) begin
      send(words[i], 1'b0, "rshs");
      if (!SHADOW) exp_regs[i] = words[i];
    end
    valid = 1'b1; data = $urandom; last = 1'b0; restart = 1'b1;
    step();
    valid = 1'b0; restart = 1'b0;
    check_status("rshs.after", 1'b1, 1'b0, 1'b0, 1'b1);
    rand_words();
    run_pass("rshs.fresh", 0, 0, '0);
    restart_pulse("rshs.rs");

    // Randomised passes.
    for (int t = 0; t < 12; t++) begin
      rand_words();
      run_pass($sformatf("rnd%0d", t), $urandom_range(0, 3), $urandom_range(0, NUM_REGS - 1),
               DATA_W'($urandom | 32'h1));
      restart_pulse($sformatf("rnd%0d.rs", t));
    end

    // Reset asserted with idx=8.
    rand_words();
    for (int i = 0; i < 8; i++) begin
      send(words[i], 1'b0, "midrst");
      if (!SHADOW) exp_regs[i] = words[i];
    end
    assert_reset("midrst.async");
    release_and_settle("midrst");
    rand_words();
    run_pass("post_rst", 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
